mem_dma: RTL and testbench



---
 rtl/mem_dma_pkg.sv | 20 ++
 rtl/mem_dma_if.sv | 45 ++++
 rtl/mem_dma.sv | 126 ++++++++++++
 tb/tb_mem_dma.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the block-copy / block-fill DMA engine: bus widths
// common to the core and data memory, transfer modes and the FSM encoding.
package mem_dma_pkg;

  localparam int AW = 8;  // address width, addresses wrap modulo 2^AW
  localparam int DW = 8;  // data width
  localparam int LW = 8;  // transfer-length width, max 2^LW-1 bytes

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FIN  = 3'd3,
    ST_ABT  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dma_if.sv
// Command and memory-bus bundle between the core, the data memory and the DMA.
//
// Handshake: start is a single-cycle request with no ready. It is taken only
// when busy is low (engine in IDLE); a start seen while busy is high is dropped,
// never queued. busy rises the cycle after acceptance and stays high until the
// engine is back in IDLE; exactly one of done / aborted pulses for one cycle at
// the end of each accepted transfer. While busy is high the DMA owns mem_addr,
// mem_din and mem_we; mem_dout is combinational from mem_addr.
interface mem_dma_if;
  import mem_dma_pkg::*;

  // command side
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic [DW-1:0] pattern;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;

  // memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  // observability of the engine FSM
  state_t        state_dbg;

  // master: the DMA engine (bus initiator)
  modport master (
    input  start, mode, src, dst, len, pattern, abort, mem_dout,
    output busy, done, aborted, mem_addr, mem_din, mem_we, state_dbg
  );

  // slave: core command port plus data memory
  modport slave (
    output start, mode, src, dst, len, pattern, abort, mem_dout,
    input  busy, done, aborted, mem_addr, mem_din, mem_we, state_dbg
  );

endinterface

// File: rtl/mem_dma.sv
// Block copy / block fill engine for the 8-bit single-port data memory.
// Copy alternates RD/WR (2 cycles per byte), fill stays in WR (1 cycle per
// byte). All outputs decode from registered state, pointers and buffer, so
// start, abort and mem_dout never reach an output combinationally.
module mem_dma
  import mem_dma_pkg::*;
(
  input logic     clk,
  input logic     rst,
  mem_dma_if.master io_bus
);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_mode;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [LW-1:0] r_len;
  logic [DW-1:0] r_pat;
  logic [LW-1:0] r_i;
  logic [DW-1:0] r_buf;
  logic [AW-1:0] r_last_addr;

  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_wr_addr;
  logic [LW-1:0] w_i_next;

  // Pointer adders wrap naturally at AW bits; the index is zero-extended.
  assign w_rd_addr = r_src + AW'(r_i);
  assign w_wr_addr = r_dst + AW'(r_i);
  assign w_i_next  = r_i + 1'b1;

  // State register; reset drops straight to IDLE, abandoning any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; abort in RD/WR overrides the final-byte transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          if (io_bus.len == '0)               w_state_next = ST_FIN;
          else if (io_bus.mode == MODE_FILL)  w_state_next = ST_WR;
          else                                w_state_next = ST_RD;
        end
      end
      ST_RD: begin
        w_state_next = io_bus.abort ? ST_ABT : ST_WR;
      end
      ST_WR: begin
        if (io_bus.abort)             w_state_next = ST_ABT;
        else if (w_i_next == r_len)   w_state_next = ST_FIN;
        else if (r_mode == MODE_FILL) w_state_next = ST_WR;
        else                          w_state_next = ST_RD;
      end
      ST_FIN:  w_state_next = ST_IDLE;
      ST_ABT:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch the command on accept, capture read data, advance index,
  // and remember the last driven address so it holds outside RD/WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_pat       <= '0;
      r_i         <= '0;
      r_buf       <= '0;
      r_last_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            r_mode <= io_bus.mode;
            r_src  <= io_bus.src;
            r_dst  <= io_bus.dst;
            r_len  <= io_bus.len;
            r_pat  <= io_bus.pattern;
            r_i    <= '0;
          end
        end
        ST_RD: begin
          r_buf       <= io_bus.mem_dout;
          r_last_addr <= w_rd_addr;
        end
        ST_WR: begin
          r_i         <= w_i_next;
          r_last_addr <= w_wr_addr;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    io_bus.mem_we   = 1'b0;
    io_bus.mem_din  = '0;
    io_bus.mem_addr = r_last_addr;
    case (r_state)
      ST_RD: begin
        io_bus.mem_addr = w_rd_addr;
      end
      ST_WR: begin
        io_bus.mem_addr = w_wr_addr;
        io_bus.mem_we   = 1'b1;
        io_bus.mem_din  = (r_mode == MODE_FILL) ? r_pat : r_buf;
      end
      default: ;
    endcase
  end

  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.done      = (r_state == ST_FIN);
  assign io_bus.aborted   = (r_state == ST_ABT);
  assign io_bus.state_dbg = r_state;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: a behavioural data memory, per-scenario tasks, and a
// scoreboard of expected bus cycles ({we, addr, data}) pushed before each
// transfer and popped as the engine performs RD/WR accesses.
module tb_mem_dma;
  import mem_dma_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_dma_if bus ();

  mem_dma dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255];
  logic       pre_we   = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_din;
    else if (pre_we) mem[pre_addr]     <= pre_data;
  end

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc, abt_cyc, n_done, n_abt, n_we;

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // Leaves the bench #1 into cycle 1 (the cycle after start is sampled).
  task automatic do_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] p);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d;
    bus.len = l; bus.pattern = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs cycles 1..budget, driving abort in cycle abt_at and a stray start in
  // cycle inj_at, popping the scoreboard on every access cycle. Returns #1 into
  // the cycle after done/aborted.
  task automatic run_xfer(input int budget, input int abt_at, input int inj_at);
    logic [16:0] e;
    bit fin;
    done_cyc = 0; abt_cyc = 0; n_done = 0; n_abt = 0; n_we = 0; fin = 1'b0;
    for (int k = 1; k <= budget && !fin; k++) begin
      bus.abort = (k == abt_at);
      if (k == inj_at) begin
        bus.start = 1'b1; bus.mode = MODE_COPY; bus.src = 8'hF0;
        bus.dst = 8'h90; bus.len = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.mem_we) n_we++;
      if (bus.done)    begin n_done++; done_cyc = k; fin = 1'b1; end
      if (bus.aborted) begin n_abt++;  abt_cyc  = k; fin = 1'b1; end
      if (bus.busy && !bus.done && !bus.aborted) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_cycle: cycle %0d got we=%b addr=%h, required no access",
                   k, bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_we !== e[16] || bus.mem_addr !== e[15:8] ||
              (e[16] && bus.mem_din !== e[7:0])) begin
            n_fail++;
            $display("FAIL bus_cycle: cycle %0d got we=%b addr=%h din=%h, required we=%b addr=%h din=%h",
                     k, bus.mem_we, bus.mem_addr, bus.mem_din, e[16], e[15:8], e[7:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL xfer_timeout: no done/aborted within %0d cycles", budget);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected accesses left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.aborted, bus.mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/aborted/we=%b, required 0000",
               {bus.busy, bus.done, bus.aborted, bus.mem_we});
    end
    n_checks++;
    if (bus.mem_addr !== 8'h00 || bus.mem_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h din=%h, required 00 00", bus.mem_addr, bus.mem_din);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.state_dbg !== ST_IDLE || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state=%0d busy=%b, required IDLE 0", bus.state_dbg, bus.busy);
    end
  endtask

  task automatic test_fill();
    poke(8'h14, 8'h77);
    for (int i = 0; i < 4; i++) push_wr(8'h10 + 8'(i), 8'hA5);
    do_start(MODE_FILL, 8'h00, 8'h10, 8'd4, 8'hA5);
    run_xfer(20, 0, 0);
    n_checks++;
    if (done_cyc != 5 || n_done != 1 || n_abt != 0 || n_we != 4) begin
      n_fail++;
      $display("FAIL fill_timing: done_cyc=%0d done=%0d abt=%0d we=%0d, required 5 1 0 4",
               done_cyc, n_done, n_abt, n_we);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL fill_busy_fall: busy=%b, required 0", bus.busy);
    end
    n_checks++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13], mem[8'h14]} !== 40'hA5A5A5A577) begin
      n_fail++;
      $display("FAIL fill_mem: %h %h %h %h %h, required a5 a5 a5 a5 77",
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13], mem[8'h14]);
    end
  endtask

  task automatic test_copy();
    poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
    for (int i = 0; i < 3; i++) begin
      push_rd(8'h20 + 8'(i));
      push_wr(8'h40 + 8'(i), 8'(i + 1));
    end
    do_start(MODE_COPY, 8'h20, 8'h40, 8'd3, 8'hFF);
    run_xfer(20, 0, 0);
    n_checks++;
    if (done_cyc != 7 || n_done != 1 || n_we != 3) begin
      n_fail++;
      $display("FAIL copy_timing: done_cyc=%0d done=%0d we=%0d, required 7 1 3",
               done_cyc, n_done, n_we);
    end
    n_checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== 24'h010203) begin
      n_fail++;
      $display("FAIL copy_mem: %h %h %h, required 01 02 03", mem[8'h40], mem[8'h41], mem[8'h42]);
    end
  endtask

  task automatic test_wrap_zero();
    push_wr(8'hFE, 8'h5C); push_wr(8'hFF, 8'h5C); push_wr(8'h00, 8'h5C);
    do_start(MODE_FILL, 8'h00, 8'hFE, 8'd3, 8'h5C);
    run_xfer(20, 0, 0);
    n_checks++;
    if (done_cyc != 4 || {mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h5C5C5C) begin
      n_fail++;
      $display("FAIL wrap_fill: done_cyc=%0d mem=%h %h %h, required 4 5c 5c 5c",
               done_cyc, mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    do_start(MODE_FILL, 8'h00, 8'h33, 8'd0, 8'hEE);
    run_xfer(10, 0, 0);
    n_checks++;
    if (done_cyc != 1 || n_we != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL zero_len: done_cyc=%0d we=%0d done=%0d, required 1 0 1",
               done_cyc, n_we, n_done);
    end
  endtask

  task automatic test_abort();
    logic [7:0] src_v [0:9];
    for (int i = 0; i < 10; i++) begin
      src_v[i] = 8'($urandom_range(0, 255));
      poke(8'h60 + 8'(i), src_v[i]);
    end
    poke(8'h83, 8'h99);
    for (int i = 0; i < 3; i++) begin
      push_rd(8'h60 + 8'(i));
      push_wr(8'h80 + 8'(i), src_v[i]);
    end
    do_start(MODE_COPY, 8'h60, 8'h80, 8'd10, 8'h00);
    run_xfer(30, 6, 0);
    n_checks++;
    if (abt_cyc != 7 || n_abt != 1 || n_done != 0 || n_we != 3) begin
      n_fail++;
      $display("FAIL abort_copy: abt_cyc=%0d abt=%0d done=%0d we=%0d, required 7 1 0 3",
               abt_cyc, n_abt, n_done, n_we);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy_fall: busy=%b, required 0", bus.busy);
    end
    n_checks++;
    if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]} !== {src_v[0], src_v[1], src_v[2], 8'h99}) begin
      n_fail++;
      $display("FAIL abort_mem: %h %h %h %h, required %h %h %h 99",
               mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83], src_v[0], src_v[1], src_v[2]);
    end
  endtask

  task automatic test_collisions();
    poke(8'h90, 8'h42);
    for (int i = 0; i < 4; i++) push_wr(8'h30 + 8'(i), 8'h11);
    do_start(MODE_FILL, 8'h00, 8'h30, 8'd4, 8'h11);
    run_xfer(20, 0, 2);
    n_checks++;
    if (done_cyc != 5 || n_done != 1 || mem[8'h90] !== 8'h42) begin
      n_fail++;
      $display("FAIL start_while_busy: done_cyc=%0d done=%0d mem90=%h, required 5 1 42",
               done_cyc, n_done, mem[8'h90]);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_start_queued: busy=%b, required 0", bus.busy);
    end
    for (int i = 0; i < 3; i++) push_wr(8'h50 + 8'(i), 8'hC3);
    do_start(MODE_FILL, 8'h00, 8'h50, 8'd3, 8'hC3);
    run_xfer(20, 3, 0);
    n_checks++;
    if (abt_cyc != 4 || n_abt != 1 || n_done != 0 || mem[8'h52] !== 8'hC3) begin
      n_fail++;
      $display("FAIL abort_last_wr: abt_cyc=%0d abt=%0d done=%0d mem52=%h, required 4 1 0 c3",
               abt_cyc, n_abt, n_done, mem[8'h52]);
    end
  endtask

  task automatic test_reset_mid();
    poke(8'hA2, 8'hEE);
    do_start(MODE_FILL, 8'h00, 8'hA0, 8'd8, 8'h6B);
    @(posedge clk); @(posedge clk);   // cycle 3 begins
    #3;
    n_checks++;
    if (bus.mem_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_fill_we: we=%b, required 1", bus.mem_we);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_we, bus.busy, bus.done, bus.aborted} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: we/busy/done/aborted=%b, required 0000",
               {bus.mem_we, bus.busy, bus.done, bus.aborted});
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.state_dbg !== ST_IDLE || bus.busy !== 1'b0 ||
        {mem[8'hA0], mem[8'hA1], mem[8'hA2]} !== 24'h6B6BEE) begin
      n_fail++;
      $display("FAIL reset_recover: state=%0d busy=%b mem=%h %h %h, required IDLE 0 6b 6b ee",
               bus.state_dbg, bus.busy, mem[8'hA0], mem[8'hA1], mem[8'hA2]);
    end
    push_wr(8'hC0, 8'h3C); push_wr(8'hC1, 8'h3C);
    do_start(MODE_FILL, 8'h00, 8'hC0, 8'd2, 8'h3C);
    run_xfer(20, 0, 0);
    n_checks++;
    if (done_cyc != 3 || n_done != 1 || {mem[8'hC0], mem[8'hC1]} !== 16'h3C3C) begin
      n_fail++;
      $display("FAIL post_reset_fill: done_cyc=%0d done=%0d mem=%h %h, required 3 1 3c 3c",
               done_cyc, n_done, mem[8'hC0], mem[8'hC1]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.pattern = '0; bus.abort = 1'b0;
    test_reset();
    test_fill();
    test_copy();
    test_wrap_zero();
    test_abort();
    test_collisions();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
